// File: rtl/mux_nx1_pipe.sv
// N-to-1 registered multiplexer with direct-select or round-robin arbitration and valid/ready handshakes.
// Optional feature: define MUX_NX1_PIPE_SKID_EN to add a one-entry skid buffer that breaks the o_ready -> i_ready path.
module mux_nx1_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_valid,
    output logic [N-1:0]       i_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   o_data,
    output logic [SEL_W-1:0]   o_src,
    output logic               o_valid,
    input  logic               o_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] last_grant, rr_idx, grant_idx, skid_src;
    logic [WIDTH-1:0] in_word, skid_data;
    logic             rr_hit, grant_hit, can_accept;
    logic             xfer_in, out_xfer, load_out, skid_full;

    // Lowest valid channel above last_grant wins; otherwise wrap to the lowest valid channel overall.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_valid[k] && (SEL_W'(k) > last_grant)) begin
                rr_hit = 1'b1;
                rr_idx = SEL_W'(k);
            end
        end
        if (!rr_hit) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (i_valid[k]) begin
                    rr_hit = 1'b1;
                    rr_idx = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_hit = rr_hit;
            grant_idx = rr_idx;
        end else begin
            grant_hit = (32'(sel) < 32'(N));
            grant_idx = sel;
        end
    end

    always_comb begin
        i_ready = '0;
        in_word = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                i_ready[k] = grant_hit && can_accept && rst_n;
                in_word    = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer_in  = |(i_valid & i_ready);
    assign o_valid  = (state == FULL);
    assign out_xfer = o_valid && o_ready;

`ifdef MUX_NX1_PIPE_SKID_EN
    // A word accepted while the output stalls parks in the skid and drains once o_ready returns.
    assign can_accept = !skid_full;
    assign load_out   = (xfer_in && (!o_valid || o_ready)) || (skid_full && o_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_src  <= '0;
        end else if (xfer_in && o_valid && !o_ready) begin
            skid_full <= 1'b1;
            skid_data <= in_word;
            skid_src  <= grant_idx;
        end else if (skid_full && o_ready) begin
            skid_full <= 1'b0;
        end
    end
`else
    assign can_accept = !o_valid || o_ready;
    assign load_out   = xfer_in;
    assign skid_full  = 1'b0;
    assign skid_data  = '0;
    assign skid_src   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= SEL_W'(N - 1);
        end else begin
            state <= state_next;
            if (xfer_in) begin
                last_grant <= grant_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (xfer_in) state_next = FULL;
            FULL:  if (out_xfer && !xfer_in && !skid_full) state_next = EMPTY;
        endcase
    end

    // The skid word is older than anything arriving, so it always goes out first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data <= '0;
            o_src  <= '0;
        end else if (load_out) begin
            if (skid_full) begin
                o_data <= skid_data;
                o_src  <= skid_src;
            end else begin
                o_data <= in_word;
                o_src  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe: directed vector table, hand-written stall/reset sequences and a random run.
// Follows MUX_NX1_PIPE_SKID_EN so the same bench covers both builds.
module tb_mux_nx1_pipe;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [N*WIDTH-1:0]   i_data = '0;
    logic [N-1:0]         i_valid = '0;
    logic [N-1:0]         i_ready;
    logic [SEL_W-1:0]     sel = '0;
    logic                 mode = 1'b0;
    logic [WIDTH-1:0]     o_data;
    logic [SEL_W-1:0]     o_src;
    logic                 o_valid;
    logic                 o_ready = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [WIDTH-1:0] mq_data[$];
    int               mq_src[$];
    int               m_last;

    typedef struct {
        logic             mode;
        logic [SEL_W-1:0] sel;
        logic [N-1:0]     valid;
        logic [N-1:0]     exp_ready;
        logic             exp_valid;
        logic [SEL_W-1:0] exp_src;
    } vec_t;

    vec_t             vecs[16];
    logic [WIDTH-1:0] chan_word[N];

    mux_nx1_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
        .sel(sel), .mode(mode), .o_data(o_data), .o_src(o_src), .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: capacity from queue depth, grant by walking offsets 1..N from the last grant.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        bit           room;
        r = '0;
`ifdef MUX_NX1_PIPE_SKID_EN
        room = (mq_data.size() < 2);
`else
        room = (mq_data.size() == 0) || o_ready;
`endif
        if (!room) return r;
        if (!mode) begin
            if (int'(sel) < N) r[sel[1:0]] = 1'b1;
        end else begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (i_valid[c]) begin
                    r[c] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        mq_data.delete();
        mq_src.delete();
        m_last = N - 1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst o_valid", 64'(o_valid), 64'd0);
        check("rst o_data", 64'(o_data), 64'd0);
        check("rst o_src", 64'(o_src), 64'd0);
        check("rst i_ready", 64'(i_ready), 64'd0);
        i_valid = '0;
        o_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_output(input logic [N-1:0] er);
        check("i_ready", 64'(i_ready), 64'(er));
        check("o_valid", 64'(o_valid), 64'(mq_data.size() > 0));
        if (mq_data.size() > 0) begin
            check("o_data", 64'(o_data), 64'(mq_data[0]));
            check("o_src", 64'(o_src), 64'(mq_src[0]));
        end
    endtask

    task automatic apply_stimulus(input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] v,
                                  input logic r, input logic [N*WIDTH-1:0] d);
        logic [N-1:0] er;
        int           g;
        @(negedge clk);
        mode = m; sel = s; i_valid = v; o_ready = r; i_data = d;
        #1;
        er = model_ready();
        check_output(er);
        @(posedge clk);
        if (mq_data.size() > 0 && r) begin
            void'(mq_data.pop_front());
            void'(mq_src.pop_front());
        end
        g = -1;
        for (int k = 0; k < N; k++) if (er[k] && v[k]) g = k;
        if (g >= 0) begin
            mq_data.push_back(d[g*WIDTH +: WIDTH]);
            mq_src.push_back(g);
            m_last = g;
        end
    endtask

    function automatic logic [N*WIDTH-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        chan_word[0] = 32'hA0A0_0000;
        chan_word[1] = 32'hB1B1_1111;
        chan_word[2] = 32'h0100_1001;
        chan_word[3] = 32'hD3D3_3333;
        //            mode  sel    valid    exp_ready exp_valid exp_src
        vecs[0]  = '{1'b0, 3'd2, 4'b0100, 4'b0100, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 3'd2, 4'b0000, 4'b0100, 1'b1, 3'd2};
        vecs[2]  = '{1'b1, 3'd0, 4'b1111, 4'b1000, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 3'd0, 4'b1111, 4'b0001, 1'b1, 3'd3};
        vecs[4]  = '{1'b1, 3'd0, 4'b1111, 4'b0010, 1'b1, 3'd0};
        vecs[5]  = '{1'b1, 3'd0, 4'b1111, 4'b0100, 1'b1, 3'd1};
        vecs[6]  = '{1'b1, 3'd0, 4'b1111, 4'b1000, 1'b1, 3'd2};
        vecs[7]  = '{1'b1, 3'd0, 4'b1111, 4'b0001, 1'b1, 3'd3};
        vecs[8]  = '{1'b1, 3'd0, 4'b0000, 4'b0000, 1'b1, 3'd0};
        vecs[9]  = '{1'b0, 3'd5, 4'b1111, 4'b0000, 1'b0, 3'd0};
        vecs[10] = '{1'b0, 3'd5, 4'b1111, 4'b0000, 1'b0, 3'd0};
        vecs[11] = '{1'b1, 3'd0, 4'b0110, 4'b0010, 1'b0, 3'd0};
        vecs[12] = '{1'b1, 3'd0, 4'b0110, 4'b0100, 1'b1, 3'd1};
        vecs[13] = '{1'b1, 3'd0, 4'b0110, 4'b0010, 1'b1, 3'd2};
        vecs[14] = '{1'b1, 3'd0, 4'b0000, 4'b0000, 1'b1, 3'd1};
        vecs[15] = '{1'b1, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0};

        #2;
        mode = 1'b1;
        i_valid = 4'b1111;
        reset_dut();

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mode = vecs[i].mode; sel = vecs[i].sel; i_valid = vecs[i].valid; o_ready = 1'b1;
            i_data = {chan_word[3], chan_word[2], chan_word[1], chan_word[0]};
            #1;
            check($sformatf("vec%0d i_ready", i), 64'(i_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d o_valid", i), 64'(o_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d o_src", i), 64'(o_src), 64'(vecs[i].exp_src));
                check($sformatf("vec%0d o_data", i), 64'(o_data), 64'(chan_word[vecs[i].exp_src]));
            end
        end

        // Backpressure with the source still pushing, then drain.
        reset_dut();
        apply_stimulus(1'b0, 3'd1, 4'b0010, 1'b1, rand_data());
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 3'd1, 4'b0010, 1'b0, rand_data());
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 3'd1, 4'b0000, 1'b1, rand_data());

        // Reset asserted while a word is held under stall; arbitration restarts at channel 0.
        apply_stimulus(1'b1, 3'd0, 4'b0100, 1'b1, rand_data());
        apply_stimulus(1'b0, 3'd1, 4'b0010, 1'b0, rand_data());
        reset_dut();
        apply_stimulus(1'b1, 3'd0, 4'b1111, 1'b1, rand_data());
        apply_stimulus(1'b1, 3'd0, 4'b1111, 1'b1, rand_data());
        apply_stimulus(1'b1, 3'd0, 4'b0000, 1'b1, rand_data());

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 4'($urandom),
                           ($urandom_range(0, 3) != 0), rand_data());
        end
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 3'd0, 4'b0000, 1'b1, rand_data());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
